// File: rtl/maxpool_stream.sv
// 2x2 / stride-2 streaming max-pool over a raster-order IMG_W x IMG_W frame.
// Even rows park pair-maxima in a half-width line buffer; odd rows finish each block and emit one write.
module maxpool_stream #(
  parameter int          IMG_W    = 64,
  parameter int          DW       = 20,
  parameter int          FRAC     = 16,
  parameter int          ROUND_UP = 1,
  parameter logic [2:0]  MEM_SEL  = 3'b011
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_valid,
  input  logic [DW-1:0] i_data,
  output logic          o_busy,
  output logic          o_wr,
  output logic [11:0]   o_addr,
  output logic [DW-1:0] o_data,
  output logic [2:0]    o_sel,
  output logic          o_done
);

  localparam int LW = $clog2(IMG_W);
  localparam int HW = IMG_W / 2;
  localparam int IW = DW - FRAC;

  logic [LW-1:0] col_q, col_d, row_q, row_d;
  logic [DW-1:0] hold_q, hold_d;
  logic          wr_q, wr_d, done_q, done_d, busy_q, busy_d;
  logic [11:0]   addr_q, addr_d;
  logic [DW-1:0] data_q, data_d;

  logic [DW-1:0] lbuf [HW];
  logic [LW-2:0] k;
  logic [DW-1:0] lbuf_rd, cmp_a, max_v, pooled;
  logic          lbuf_we;

  function automatic logic [DW-1:0] ceil_fx(input logic [DW-1:0] v);
    logic [IW-1:0] ip;
    ip = v[DW-1:FRAC] + IW'(1);
    if (v[FRAC-1:0] == '0)
      return v;
    else if (&v[DW-1:FRAC])
      return '1;
    else
      return {ip, {FRAC{1'b0}}};
  endfunction

  assign k       = col_q[LW-1:1];
  assign lbuf_rd = lbuf[k];
  // Only the odd-row/even-column sample merges against the stored upper pair.
  assign cmp_a   = (row_q[0] && !col_q[0]) ? lbuf_rd : hold_q;
  assign max_v   = (i_data > cmp_a) ? i_data : cmp_a;
  assign lbuf_we = i_valid && !row_q[0] && col_q[0];

  generate
    if (ROUND_UP != 0) begin : g_ceil
      assign pooled = ceil_fx(max_v);
    end else begin : g_pass
      assign pooled = max_v;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (lbuf_we) lbuf[k] <= max_v;
  end

  always_comb begin
    col_d  = col_q;
    row_d  = row_q;
    hold_d = hold_q;
    wr_d   = 1'b0;
    done_d = 1'b0;
    addr_d = addr_q;
    data_d = data_q;
    busy_d = busy_q;
    if (done_q) busy_d = 1'b0;
    if (i_valid) begin
      col_d = col_q + LW'(1);
      if (&col_q) row_d = row_q + LW'(1);
      if (row_q == '0 && col_q == '0) busy_d = 1'b1;
      if (!col_q[0]) hold_d = row_q[0] ? max_v : i_data;
      if (row_q[0] && col_q[0]) begin
        wr_d   = 1'b1;
        done_d = &col_q && &row_q;
        addr_d = 12'({row_q[LW-1:1], k});
        data_d = pooled;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_q  <= '0;
      row_q  <= '0;
      hold_q <= '0;
      wr_q   <= 1'b0;
      done_q <= 1'b0;
      busy_q <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      col_q  <= col_d;
      row_q  <= row_d;
      hold_q <= hold_d;
      wr_q   <= wr_d;
      done_q <= done_d;
      busy_q <= busy_d;
      addr_q <= addr_d;
      data_q <= data_d;
    end
  end

  assign o_busy = busy_q;
  assign o_wr   = wr_q;
  assign o_addr = addr_q;
  assign o_data = data_q;
  assign o_done = done_q;
  assign o_sel  = wr_q ? MEM_SEL : 3'b000;

endmodule

// File: tb/tb_maxpool_stream.sv
// Directed bench for maxpool_stream: a pass-through instance (ROUND_UP=0) and a ceiling
// instance (ROUND_UP=1) share one input stream; writes are captured each cycle and checked.
module tb_maxpool_stream;

  logic        clk = 1'b0;
  logic        reset, i_valid;
  logic [19:0] i_data;
  logic        busy0, wr0, done0, busy1, wr1, done1;
  logic [11:0] addr0, addr1;
  logic [19:0] data0, data1;
  logic [2:0]  sel0, sel1;

  always #5 clk = ~clk;

  maxpool_stream #(.ROUND_UP(0)) u_pass (
    .clk(clk), .reset(reset), .i_valid(i_valid), .i_data(i_data),
    .o_busy(busy0), .o_wr(wr0), .o_addr(addr0), .o_data(data0), .o_sel(sel0), .o_done(done0)
  );

  maxpool_stream #(.ROUND_UP(1)) u_ceil (
    .clk(clk), .reset(reset), .i_valid(i_valid), .i_data(i_data),
    .o_busy(busy1), .o_wr(wr1), .o_addr(addr1), .o_data(data1), .o_sel(sel1), .o_done(done1)
  );

  int tests = 0, fails = 0, tk = 0;
  int wa[$], wd[$], ws[$], wt[$], wdn[$], ca[$], cd[$], cs[$], odd_t[$], fs_q[$];
  bit bz[$];
  int hold_err, done_stray, mr, mc;
  logic [11:0] last_a = '0;
  logic [19:0] last_d = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [19:0] gen(input int mode, input int r, input int c);
    int b, p, idx;
    b = c >> 1;
    p = (r % 2) * 2 + (c % 2);
    idx = r * 64 + c;
    case (mode)
      0: return 20'(idx);
      1: return 20'(4095 - idx);
      2: begin
        if (r >= 2) return 20'h0;
        case (b)
          0: return (p == 0) ? 20'h08000 : 20'h00001;
          1: return (p == 3) ? 20'h20000 : 20'h1FFFF;
          2: return (p == 1) ? 20'hF0001 : 20'h00000;
          4: return (p == 2) ? 20'h20001 : 20'h10000;
          default: return 20'h0;
        endcase
      end
      default: begin
        if (r >= 2) return 20'h0;
        if (b < 4) return (p == b) ? 20'h123 : 20'(17 * (p + 1));
        if (b == 4) return 20'h55;
        if (b == 5) return (p == 0) ? 20'h80000 : 20'h7FFFF;
        return 20'h0;
      end
    endcase
  endfunction

  function automatic logic [19:0] exp_max(input int mode, input int br, input int bc);
    logic [19:0] m, v;
    m = 20'h0;
    for (int dr = 0; dr < 2; dr++)
      for (int dc = 0; dc < 2; dc++) begin
        v = gen(mode, 2 * br + dr, 2 * bc + dc);
        if (v > m) m = v;
      end
    return m;
  endfunction

  // One clock: sample outputs on the falling edge, then drive the next input.
  task automatic tick(input bit v, input logic [19:0] d);
    @(negedge clk);
    bz.push_back(busy0);
    if (wr0) begin
      wa.push_back(int'(addr0)); wd.push_back(int'(data0)); ws.push_back(int'(sel0));
      wt.push_back(tk); wdn.push_back(int'(done0));
    end else begin
      if (addr0 !== last_a || data0 !== last_d) hold_err++;
      if (done0) done_stray++;
    end
    last_a = addr0;
    last_d = data0;
    if (wr1) begin
      ca.push_back(int'(addr1)); cd.push_back(int'(data1)); cs.push_back(int'(sel1));
    end
    i_valid = v;
    i_data  = d;
    if (v) begin
      if (mr % 2 == 1 && mc % 2 == 1) odd_t.push_back(tk);
      mc = (mc + 1) % 64;
      if (mc == 0) mr = (mr + 1) % 64;
    end
    tk++;
  endtask

  task automatic run_frame(input int mode, input int gap_pct);
    for (int r = 0; r < 64; r++)
      for (int c = 0; c < 64; c++) begin
        for (int g = 0; g < 5 && gap_pct > 0 && $urandom_range(0, 99) < gap_pct; g++)
          tick(1'b0, 20'($urandom));
        if (r == 0 && c == 0) fs_q.push_back(tk);
        tick(1'b1, gen(mode, r, c));
      end
  endtask

  task automatic flush();
    repeat (3) tick(1'b0, 20'h0);
  endtask

  task automatic clear();
    wa.delete(); wd.delete(); ws.delete(); wt.delete(); wdn.delete();
    ca.delete(); cd.delete(); cs.delete(); odd_t.delete(); fs_q.delete();
    hold_err = 0;
    done_stray = 0;
  endtask

  task automatic check_frames(input string tag, input int mode, input int n);
    int lim, ea, ed, el, dn, dpos, zeros, s, f;
    lim = n * 1024;
    chk({tag, "_count"}, wa.size(), lim);
    if (wa.size() < lim) lim = wa.size();
    if (odd_t.size() < lim) lim = odd_t.size();
    ea = 0; ed = 0; el = 0; dn = 0; dpos = 0;
    for (int i = 0; i < lim; i++) begin
      if (wa[i] != i % 1024) ea++;
      if (wd[i] != int'(exp_max(mode, (i % 1024) / 32, i % 32))) ed++;
      if (wt[i] != odd_t[i] + 1) el++;
      if (wdn[i] != 0) begin
        dn++;
        if (i % 1024 != 1023) dpos++;
      end
    end
    chk({tag, "_addr_errs"}, ea, 0);
    chk({tag, "_data_errs"}, ed, 0);
    chk({tag, "_latency_errs"}, el, 0);
    chk({tag, "_done_pulses"}, dn, n);
    chk({tag, "_done_misplaced"}, dpos + done_stray, 0);
    chk({tag, "_hold_errs"}, hold_err, 0);
    if (fs_q.size() > 0 && wt.size() > 0) begin
      s = fs_q[0];
      f = wt[wt.size() - 1];
      zeros = 0;
      for (int t = s + 1; t <= f; t++) if (!bz[t]) zeros++;
      chk({tag, "_busy_before"}, 32'(bz[s]), 0);
      chk({tag, "_busy_dropouts"}, zeros, 0);
      chk({tag, "_busy_fall"}, 32'(bz[f + 1]), 0);
    end else begin
      chk({tag, "_frame_seen"}, 0, 1);
    end
  endtask

  initial begin
    int nz;
    reset = 1'b1; i_valid = 1'b0; i_data = '0; mr = 0; mc = 0;
    clear();
    repeat (2) @(negedge clk);
    chk("rst_outputs", {busy0, wr0, done0, sel0, addr0, data0}, 0);
    chk("rst_ceil_outputs", {busy1, wr1, done1, sel1}, 0);
    reset = 1'b0;
    repeat (2) tick(1'b0, 20'h0);

    // Ramp, continuous
    clear();
    run_frame(0, 0);
    flush();
    chk("ramp_addr0", wa[0], 0);
    chk("ramp_data0", wd[0], 65);
    chk("ramp_addr1", wa[1], 1);
    chk("ramp_data1", wd[1], 67);
    chk("ramp_addr1023", wa[1023], 1023);
    chk("ramp_data1023", wd[1023], 4095);
    chk("ramp_done_last", wdn[1023], 1);
    chk("ramp_sel_on_wr", ws[0], 3);
    chk("idle_sel", 32'(sel0), 0);
    check_frames("ramp", 0, 1);

    // Reverse ramp with random idle gaps
    clear();
    run_frame(1, 30);
    flush();
    chk("rev_data0", wd[0], 4095);
    chk("rev_data1023", wd[1023], 65);
    check_frames("rev", 1, 1);

    // Ceil rounding on the ROUND_UP=1 instance
    clear();
    run_frame(2, 0);
    flush();
    chk("ceil_count", ca.size(), 1024);
    chk("ceil_b0", cd[0], 32'h10000);
    chk("ceil_b1", cd[1], 32'h20000);
    chk("ceil_b2_sat", cd[2], 32'hFFFFF);
    chk("ceil_b3_zero", cd[3], 32'h0);
    chk("ceil_b4", cd[4], 32'h30000);
    chk("ceil_sel", cs[0] | cs[1] | cs[2] | cs[3], 3);
    chk("ceil_addr3", ca[3], 3);
    nz = 0;
    for (int i = 5; i < ca.size(); i++) if (cd[i] != 0) nz++;
    chk("ceil_rest_zero", nz, 0);
    chk("pass_b2_raw", wd[2], 32'hF0001);
    check_frames("round_pass", 2, 1);

    // Max position, ties, MSB compare
    clear();
    run_frame(3, 0);
    flush();
    chk("pos_00", wd[0], 32'h123);
    chk("pos_01", wd[1], 32'h123);
    chk("pos_10", wd[2], 32'h123);
    chk("pos_11", wd[3], 32'h123);
    chk("pos_tie", wd[4], 32'h55);
    chk("pos_msb", wd[5], 32'h80000);
    check_frames("pos", 3, 1);

    // Reset mid-frame
    clear();
    for (int i = 0; i < 1000; i++) tick(1'b1, gen(0, i / 64, i % 64));
    chk("mid_busy_before_rst", 32'(busy0), 1);
    #2 reset = 1'b1;
    i_valid = 1'b0;
    #1;
    chk("mid_rst_outputs", {busy0, wr0, done0, sel0, addr0, data0}, 0);
    mr = 0; mc = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    last_a = '0; last_d = '0;
    clear();
    repeat (5) tick(1'b0, 20'($urandom));
    chk("mid_no_writes", wa.size(), 0);
    clear();
    run_frame(0, 0);
    flush();
    chk("mid_fresh_data0", wd[0], 65);
    chk("mid_fresh_data1023", wd[1023], 4095);
    check_frames("mid_fresh", 0, 1);

    // Two back-to-back frames
    clear();
    run_frame(0, 0);
    run_frame(0, 0);
    flush();
    chk("b2b_done1", wdn[1023], 1);
    chk("b2b_done2", wdn[2047], 1);
    chk("b2b_addr_wrap", wa[1024], 0);
    check_frames("b2b", 0, 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
